// File: rtl/conv_2_fm_writer.sv
// conv_2 write-back: adds the per-map bias to each MAC result, applies ReLU with
// saturation and writes N_FM x OUT_PIX pixels into the output feature-map BRAM.
module conv_2_fm_writer #(
    parameter int DATA_W    = 16,
    parameter int N_FM      = 8,
    parameter int OUT_PIX   = 100,
    parameter int ADDR_W    = 10,
    parameter int BIAS_BASE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conv_2_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bias_bram_en,
    output logic [6:0]        bias_bram_addr,
    input  logic [DATA_W-1:0] bias_bram_dout,
    output logic              ofm_bram_we,
    output logic [ADDR_W-1:0] ofm_bram_addr,
    output logic [DATA_W-1:0] ofm_bram_din,
    output logic              wr_finish
);

    localparam int FM_W  = (N_FM > 1) ? $clog2(N_FM) : 1;
    localparam int PIX_W = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_BIAS_REQ  = 3'd1,
        S_BIAS_WAIT = 3'd2,
        S_STREAM    = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // Signed add on DATA_W+1 bits, clamp negatives to 0 and overflow to max positive.
    function automatic logic [DATA_W-1:0] relu_sat(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W]) begin
            relu_sat = '0;
        end else if (s[DATA_W-1]) begin
            relu_sat = {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            relu_sat = s[DATA_W-1:0];
        end
    endfunction

    state_t              state_q, state_d;
    logic                en_q;
    logic [FM_W-1:0]     fm_q, fm_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [DATA_W-1:0]   bias_q, bias_d;
    logic                in_ready_q;
    logic                bias_en_q;
    logic [6:0]          bias_addr_q, bias_addr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                finish_q, finish_d;
    logic                rise_s;
    logic                accept_s;
    logic                abort_s;

    // Next-state, counter and write-port logic.
    always_comb begin
        state_d     = state_q;
        fm_d        = fm_q;
        pix_d       = pix_q;
        bias_d      = bias_q;
        finish_d    = finish_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        bias_addr_d = bias_addr_q;

        rise_s   = conv_2_en & ~en_q;
        // in_ready_q is only ever high in STREAM, so it also qualifies the state.
        accept_s = in_valid & in_ready_q & ~rise_s;
        abort_s  = ~conv_2_en & (state_q != S_IDLE) & (state_q != S_DONE);

        if (accept_s) begin
            we_d   = 1'b1;
            addr_d = ADDR_W'(fm_q) * ADDR_W'(OUT_PIX) + ADDR_W'(pix_q);
            din_d  = relu_sat(in_data, bias_q);
        end else begin
            we_d   = 1'b0;
        end

        if (rise_s) begin
            fm_d     = '0;
            pix_d    = '0;
            finish_d = 1'b0;
            state_d  = S_BIAS_REQ;
        end else if (abort_s) begin
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_BIAS_REQ:  state_d = S_BIAS_WAIT;
                S_BIAS_WAIT: begin
                    bias_d  = bias_bram_dout;
                    state_d = S_STREAM;
                end
                S_STREAM: begin
                    if (accept_s) begin
                        if (pix_q == PIX_W'(OUT_PIX - 1)) begin
                            pix_d = '0;
                            // The last map parks its counter instead of stepping past N_FM-1.
                            if (fm_q == FM_W'(N_FM - 1)) begin
                                state_d  = S_DONE;
                                finish_d = 1'b1;
                            end else begin
                                fm_d    = fm_q + FM_W'(1);
                                state_d = S_BIAS_REQ;
                            end
                        end else begin
                            pix_d = pix_q + PIX_W'(1);
                        end
                    end else begin
                        state_d = S_STREAM;
                    end
                end
                S_IDLE:  state_d = S_IDLE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d == S_BIAS_REQ) begin
            bias_addr_d = 7'(BIAS_BASE) + 7'(fm_d);
        end else begin
            bias_addr_d = bias_addr_q;
        end
    end

    // State and registered outputs; handshake/enable outputs decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            en_q        <= 1'b0;
            fm_q        <= '0;
            pix_q       <= '0;
            bias_q      <= '0;
            in_ready_q  <= 1'b0;
            bias_en_q   <= 1'b0;
            bias_addr_q <= 7'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= conv_2_en;
            fm_q        <= fm_d;
            pix_q       <= pix_d;
            bias_q      <= bias_d;
            in_ready_q  <= (state_d == S_STREAM);
            bias_en_q   <= (state_d == S_BIAS_REQ);
            bias_addr_q <= bias_addr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            finish_q    <= finish_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign bias_bram_en   = bias_en_q;
    assign bias_bram_addr = bias_addr_q;
    assign ofm_bram_we    = we_q;
    assign ofm_bram_addr  = addr_q;
    assign ofm_bram_din   = din_q;
    assign wr_finish      = finish_q;

endmodule
